amm_cmd_executor: RTL and testbench

- Consumer end of the operation handshake driven by control_block.
- Accepts one write or read transaction descriptor per handshake and turns it into Avalon-MM master commands.
- Writes: burst with a fixed data pattern and byte masks derived from the start/end offsets. Reads: a single burst command.
- Tracks outstanding read words so the test sequencer knows when the memory has drained.

---
 rtl/memory_checker_pkg.sv | 21 ++
 rtl/amm_cmd_executor_byte_mask_gen.sv | 22 ++
 rtl/amm_cmd_executor.sv | 191 +++++++++++++++++++
 tb/tb_amm_cmd_executor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_checker_pkg.sv
// Shared definitions for the memory checker: addressing mode, transaction
// descriptor layout and operation-type encodings.
package memory_checker_pkg;

  typedef enum logic {BYTE, WORD} addr_type_t;

  localparam int unsigned TXN_ADDR_W  = 8;
  localparam int unsigned TXN_BURST_W = 11;
  localparam int unsigned TXN_OFFS_W  = 4;

  typedef struct packed {
    logic [TXN_ADDR_W-1:0]  word_address;
    logic [TXN_BURST_W-1:0] word_burst_count;
    logic [TXN_OFFS_W-1:0]  start_offset;
    logic [TXN_OFFS_W-1:0]  end_offset;
  } transaction_type;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

endpackage

// File: rtl/amm_cmd_executor_byte_mask_gen.sv
// Byte-enable mask for one write beat: first beat trims the low bytes below
// the start offset, last beat trims the high bytes above the end offset.
module byte_mask_gen #(
  parameter int unsigned BYTE_PER_WORD = 16,
  parameter int unsigned BYTE_ADDR_W   = $clog2(BYTE_PER_WORD)
) (
  input  logic [BYTE_ADDR_W-1:0]   i_start_offset,
  input  logic [BYTE_ADDR_W-1:0]   i_end_offset,
  input  logic                     i_first,
  input  logic                     i_last,
  output logic [BYTE_PER_WORD-1:0] o_mask
);

  always_comb begin
    o_mask = '1;
    for (int unsigned i = 0; i < BYTE_PER_WORD; i++) begin
      if (i_first && (BYTE_ADDR_W'(i) < i_start_offset)) o_mask[i] = 1'b0;
      if (i_last && (BYTE_ADDR_W'(i) > i_end_offset))    o_mask[i] = 1'b0;
    end
  end

endmodule

// File: rtl/amm_cmd_executor.sv
// Turns accepted write/read descriptors into Avalon-MM burst commands and
// tracks outstanding read words.
module amm_cmd_executor
  import memory_checker_pkg::*;
#(
  parameter int unsigned AMM_DATA_W    = 128,
  parameter int unsigned AMM_ADDR_W    = 12,
  parameter int unsigned AMM_BURST_W   = 11,
  parameter addr_type_t  ADDR_TYPE     = BYTE,
  parameter int unsigned BYTE_PER_WORD = AMM_DATA_W / 8,
  parameter int unsigned BYTE_ADDR_W   = $clog2(BYTE_PER_WORD),
  parameter int unsigned ADDR_W        = AMM_ADDR_W - BYTE_ADDR_W,
  parameter int unsigned MAX_PENDING   = 64,
  parameter int unsigned PEND_W        = $clog2(MAX_PENDING + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     op_valid_i,
  input  logic                     op_type_i,
  input  logic [ADDR_W-1:0]        op_word_addr_i,
  input  logic [AMM_BURST_W-1:0]   op_burst_cnt_i,
  input  logic [BYTE_ADDR_W-1:0]   op_start_offset_i,
  input  logic [BYTE_ADDR_W-1:0]   op_end_offset_i,
  output logic                     cmd_accept_ready_o,
  input  logic [AMM_DATA_W-1:0]    data_pattern_i,
  output logic [AMM_ADDR_W-1:0]    amm_address_o,
  output logic                     amm_write_o,
  output logic                     amm_read_o,
  output logic [AMM_DATA_W-1:0]    amm_writedata_o,
  output logic [BYTE_PER_WORD-1:0] amm_byteenable_o,
  output logic [AMM_BURST_W-1:0]   amm_burstcount_o,
  input  logic                     amm_waitrequest_i,
  input  logic                     amm_readdatavalid_i,
  output logic                     busy_o,
  output logic                     unexpected_rdv_o
);

  // Limit check is widened to hold a full burst count as well as the counter.
  localparam int unsigned CMP_W = ((PEND_W > AMM_BURST_W) ? PEND_W : AMM_BURST_W) + 1;

  typedef enum logic [1:0] {IDLE_S, WRITE_S, READ_S} state_t;

  state_t                   r_state, w_state_nxt;
  logic [AMM_BURST_W-1:0]   r_beat, w_beat_nxt;
  logic [BYTE_ADDR_W-1:0]   r_start, w_start_nxt;
  logic [BYTE_ADDR_W-1:0]   r_end, w_end_nxt;
  logic [PEND_W-1:0]        r_pending, w_pending_nxt;
  logic                     r_rdy, r_busy, r_unexp;
  logic [AMM_ADDR_W-1:0]    r_address, w_addr_nxt, w_addr_fmt;
  logic                     r_write, w_write_nxt;
  logic                     r_read, w_read_nxt;
  logic [AMM_DATA_W-1:0]    r_wdata, w_wdata_nxt;
  logic [BYTE_PER_WORD-1:0] r_be, w_be_nxt, w_mask;
  logic [AMM_BURST_W-1:0]   r_bcnt, w_bcnt_nxt, w_next_beat;
  logic                     w_is_read, w_blocked, w_ready, w_accept, w_dec;
  logic                     w_first, w_mlast;
  logic [BYTE_ADDR_W-1:0]   w_mstart, w_mend;
  logic [CMP_W-1:0]         w_inc, w_pend_sum;

  always_comb begin
    w_is_read  = (op_type_i == OP_READ);
    w_blocked  = w_is_read &&
                 ((CMP_W'(r_pending) + CMP_W'(op_burst_cnt_i)) > CMP_W'(MAX_PENDING));
    w_ready    = r_rdy && !w_blocked;
    w_accept   = op_valid_i && w_ready;
    w_addr_fmt = (ADDR_TYPE == BYTE) ? {op_word_addr_i, {BYTE_ADDR_W{1'b0}}}
                                     : AMM_ADDR_W'(op_word_addr_i);
    // One mask generator serves both beat 0 (from the descriptor) and later beats.
    w_next_beat = r_beat + AMM_BURST_W'(1);
    w_first     = (r_state == IDLE_S);
    w_mstart    = w_first ? op_start_offset_i : r_start;
    w_mend      = w_first ? op_end_offset_i : r_end;
    w_mlast     = w_first ? (op_burst_cnt_i == AMM_BURST_W'(1))
                          : (w_next_beat == r_bcnt - AMM_BURST_W'(1));
  end

  byte_mask_gen #(
    .BYTE_PER_WORD (BYTE_PER_WORD),
    .BYTE_ADDR_W   (BYTE_ADDR_W)
  ) u_mask (
    .i_start_offset (w_mstart),
    .i_end_offset   (w_mend),
    .i_first        (w_first),
    .i_last         (w_mlast),
    .o_mask         (w_mask)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_start_nxt = r_start;
    w_end_nxt   = r_end;
    w_addr_nxt  = r_address;
    w_write_nxt = r_write;
    w_read_nxt  = r_read;
    w_wdata_nxt = r_wdata;
    w_be_nxt    = r_be;
    w_bcnt_nxt  = r_bcnt;
    unique case (r_state)
      IDLE_S: begin
        if (w_accept) begin
          w_start_nxt = op_start_offset_i;
          w_end_nxt   = op_end_offset_i;
          w_addr_nxt  = w_addr_fmt;
          w_bcnt_nxt  = op_burst_cnt_i;
          w_wdata_nxt = data_pattern_i;
          w_beat_nxt  = '0;
          if (w_is_read) begin
            w_state_nxt = READ_S;
            w_read_nxt  = 1'b1;
            w_be_nxt    = '1;
          end else begin
            w_state_nxt = WRITE_S;
            w_write_nxt = 1'b1;
            w_be_nxt    = w_mask;
          end
        end
      end
      WRITE_S: begin
        if (!amm_waitrequest_i) begin
          if (r_beat == r_bcnt - AMM_BURST_W'(1)) begin
            w_state_nxt = IDLE_S;
            w_write_nxt = 1'b0;
          end else begin
            w_beat_nxt = w_next_beat;
            w_be_nxt   = w_mask;
          end
        end
      end
      READ_S: begin
        if (!amm_waitrequest_i) begin
          w_state_nxt = IDLE_S;
          w_read_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE_S;
    endcase
  end

  always_comb begin
    w_inc         = (w_accept && w_is_read) ? CMP_W'(op_burst_cnt_i) : '0;
    w_dec         = amm_readdatavalid_i && (r_pending != '0);
    w_pend_sum    = CMP_W'(r_pending) + w_inc - CMP_W'(w_dec);
    w_pending_nxt = PEND_W'(w_pend_sum);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= IDLE_S;
      r_beat    <= '0;
      r_start   <= '0;
      r_end     <= '0;
      r_pending <= '0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
      r_unexp   <= 1'b0;
      r_address <= '0;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_bcnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_beat    <= w_beat_nxt;
      r_start   <= w_start_nxt;
      r_end     <= w_end_nxt;
      r_pending <= w_pending_nxt;
      r_rdy     <= (w_state_nxt == IDLE_S);
      r_busy    <= (w_state_nxt != IDLE_S) || (w_pending_nxt != '0);
      r_unexp   <= r_unexp || (amm_readdatavalid_i && (r_pending == '0));
      r_address <= w_addr_nxt;
      r_write   <= w_write_nxt;
      r_read    <= w_read_nxt;
      r_wdata   <= w_wdata_nxt;
      r_be      <= w_be_nxt;
      r_bcnt    <= w_bcnt_nxt;
    end
  end

  assign cmd_accept_ready_o = w_ready;
  assign amm_address_o      = r_address;
  assign amm_write_o        = r_write;
  assign amm_read_o         = r_read;
  assign amm_writedata_o    = r_wdata;
  assign amm_byteenable_o   = r_be;
  assign amm_burstcount_o   = r_bcnt;
  assign busy_o             = r_busy;
  assign unexpected_rdv_o   = r_unexp;

endmodule

// File: tb/tb_amm_cmd_executor.sv
// Scoreboarded random bench for amm_cmd_executor with a queue/counter model.
module tb_amm_cmd_executor;
  import memory_checker_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         op_valid_i = 1'b0;
  logic         op_type_i = 1'b0;
  logic [7:0]   op_word_addr_i = '0;
  logic [10:0]  op_burst_cnt_i = 11'd1;
  logic [3:0]   op_start_offset_i = '0;
  logic [3:0]   op_end_offset_i = '0;
  logic         cmd_accept_ready_o;
  logic [127:0] data_pattern_i = '0;
  logic [11:0]  amm_address_o;
  logic         amm_write_o;
  logic         amm_read_o;
  logic [127:0] amm_writedata_o;
  logic [15:0]  amm_byteenable_o;
  logic [10:0]  amm_burstcount_o;
  logic         amm_waitrequest_i = 1'b0;
  logic         amm_readdatavalid_i = 1'b0;
  logic         busy_o;
  logic         unexpected_rdv_o;

  amm_cmd_executor #(.MAX_PENDING(8)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .op_valid_i          (op_valid_i),
    .op_type_i           (op_type_i),
    .op_word_addr_i      (op_word_addr_i),
    .op_burst_cnt_i      (op_burst_cnt_i),
    .op_start_offset_i   (op_start_offset_i),
    .op_end_offset_i     (op_end_offset_i),
    .cmd_accept_ready_o  (cmd_accept_ready_o),
    .data_pattern_i      (data_pattern_i),
    .amm_address_o       (amm_address_o),
    .amm_write_o         (amm_write_o),
    .amm_read_o          (amm_read_o),
    .amm_writedata_o     (amm_writedata_o),
    .amm_byteenable_o    (amm_byteenable_o),
    .amm_burstcount_o    (amm_burstcount_o),
    .amm_waitrequest_i   (amm_waitrequest_i),
    .amm_readdatavalid_i (amm_readdatavalid_i),
    .busy_o              (busy_o),
    .unexpected_rdv_o    (unexpected_rdv_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           is_wr;
    logic [11:0]  addr;
    logic [15:0]  be;
    logic [127:0] data;
    logic [10:0]  bcnt;
  } beat_t;

  beat_t exp_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    m_pend  = 0;
  bit    m_unexp = 0;
  bit    m_out   = 0;
  bit    popped  = 0;
  bit    wait_en = 0;
  bit    rdv_en  = 0;
  bit    force_rdv = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] exp_mask(input int k, input int n, input int so, input int eo);
    int lo, hi, m;
    lo = (k == 0) ? so : 0;
    hi = (k == n - 1) ? eo : 15;
    m  = ((1 << (hi + 1)) - 1) & ~((1 << lo) - 1);
    return m[15:0];
  endfunction

  // Monitor: every bus handshake retires the oldest expected command/beat.
  always @(negedge clk_i) begin
    if (rst_i && !amm_waitrequest_i && (amm_write_o || amm_read_o)) begin
      if (exp_q.size() == 0) begin
        check("spurious_cmd", {amm_write_o, amm_read_o}, 2'b00);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        popped = 1;
        check("cmd_is_write", amm_write_o, e.is_wr);
        check("cmd_is_read", amm_read_o, !e.is_wr);
        check("address", amm_address_o, e.addr);
        check("burstcount", amm_burstcount_o, e.bcnt);
        check("byteenable", amm_byteenable_o, e.be);
        if (e.is_wr) check("writedata", amm_writedata_o, e.data);
      end
    end
  end

  // Called at +1 after an edge; checks status at +7, advances the model for
  // the coming edge, then drives fresh random handshake inputs at +1.
  task automatic tick(output bit acc);
    bit active, blocked, exp_rdy;
    #6;
    active  = (exp_q.size() != 0) || popped;
    blocked = op_type_i && ((m_pend + int'(op_burst_cnt_i)) > 8);
    exp_rdy = m_out && !active && !blocked;
    check("ready", cmd_accept_ready_o, exp_rdy);
    check("busy", busy_o, active || (m_pend != 0));
    check("unexpected_rdv", unexpected_rdv_o, m_unexp);
    popped = 0;
    acc = op_valid_i && exp_rdy;
    if (acc) begin
      beat_t b;
      b.addr = {op_word_addr_i, 4'h0};
      b.bcnt = op_burst_cnt_i;
      b.data = data_pattern_i;
      if (op_type_i) begin
        b.is_wr = 0;
        b.be    = 16'hFFFF;
        exp_q.push_back(b);
      end else begin
        b.is_wr = 1;
        for (int k = 0; k < int'(op_burst_cnt_i); k++) begin
          b.be = exp_mask(k, int'(op_burst_cnt_i), int'(op_start_offset_i), int'(op_end_offset_i));
          exp_q.push_back(b);
        end
      end
    end
    if (amm_readdatavalid_i) begin
      if (m_pend == 0) m_unexp = 1;
      else m_pend--;
    end
    if (acc && op_type_i) m_pend += int'(op_burst_cnt_i);
    @(posedge clk_i); #1;
    amm_waitrequest_i   = wait_en && ($urandom_range(0, 2) == 0);
    amm_readdatavalid_i = force_rdv || (rdv_en && (m_pend > 0) && ($urandom_range(0, 1) == 1));
  endtask

  task automatic do_op(input bit typ, input int addr, input int burst, input int so, input int eo);
    bit acc;
    acc = 0;
    op_valid_i        = 1'b1;
    op_type_i         = typ;
    op_word_addr_i    = addr[7:0];
    op_burst_cnt_i    = burst[10:0];
    op_start_offset_i = so[3:0];
    op_end_offset_i   = eo[3:0];
    data_pattern_i    = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 300 && !acc; n++) tick(acc);
    op_valid_i = 1'b0;
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    bit acc;
    for (int n = 0; n < 300 && (exp_q.size() != 0 || popped); n++) tick(acc);
    if (exp_q.size() != 0) check("idle_timeout", exp_q.size(), 0);
  endtask

  task automatic drain();
    bit acc;
    rdv_en = 1;
    for (int n = 0; n < 500 && m_pend != 0; n++) tick(acc);
    if (m_pend != 0) check("drain_timeout", m_pend, 0);
  endtask

  task automatic reset_dut();
    rst_i = 1'b0;
    op_valid_i = 1'b0;
    amm_readdatavalid_i = 1'b0;
    amm_waitrequest_i = 1'b0;
    m_out = 0;
    #6;
    exp_q.delete();
    popped = 0;
    m_pend = 0;
    m_unexp = 0;
    @(posedge clk_i); #6;
    check("rst_amm_ctrl", {amm_write_o, amm_read_o, amm_address_o, amm_byteenable_o, amm_burstcount_o}, '0);
    check("rst_wdata", amm_writedata_o, '0);
    check("rst_status", {busy_o, unexpected_rdv_o}, 2'b00);
    check("rst_ready", cmd_accept_ready_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #6;
    check("rst_ready_release", cmd_accept_ready_o, 1'b0);
    @(posedge clk_i); #1;
    m_out = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    @(posedge clk_i); #1;
    reset_dut();

    wait_en = 0; rdv_en = 0;
    do_op(OP_WRITE, 8'h05, 1, 3, 10);
    wait_idle();
    wait_en = 1;
    do_op(OP_WRITE, 8'h10, 3, 4, 1);
    wait_idle();

    wait_en = 0;
    do_op(OP_READ, 8'h20, 8, 0, 15);
    wait_idle();
    rdv_en = 1;
    do_op(OP_READ, 8'h21, 1, 0, 15);
    wait_idle();
    drain();

    wait_en = 1;
    for (int i = 0; i < 40; i++) begin
      bit typ;
      typ = ($urandom_range(0, 1) == 1);
      do_op(typ, int'($urandom_range(0, 255)), int'($urandom_range(1, 8)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    drain();

    wait_en = 0; rdv_en = 0;
    do_op(OP_READ, 8'h40, 3, 0, 15);
    wait_idle();
    do_op(OP_WRITE, 8'h30, 4, 2, 5);
    tick(acc);
    tick(acc);
    reset_dut();
    check("post_rst_pending", busy_o, 1'b0);

    rdv_en = 0;
    force_rdv = 1;
    tick(acc);
    force_rdv = 0;
    amm_readdatavalid_i = 1'b0;
    wait_en = 1;
    do_op(OP_WRITE, 8'h7F, 2, 15, 0);
    wait_idle();
    rdv_en = 1;
    do_op(OP_READ, 8'hFF, 2, 0, 15);
    wait_idle();
    drain();
    tick(acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
